// File: rtl/nibble_seq_addsub.sv
// nibble_seq_addsub -- sequential 8-bit add/subtract unit.
//
// A single 4-bit carry-lookahead nibble adder is time-multiplexed: the low
// nibble is summed in state LO, the high nibble in state HI, and the
// inter-nibble carry is registered in between. Results and flags are held
// in DONE until the downstream handshake. The unit can accept a new
// operation in the same cycle as that handshake (back-to-back).
//
// Optional feature: define NSA_SAT_EN to enable signed saturation when
// op_i[1]=1. Without the macro, op_i[1] is ignored and the result is always
// the raw wrapped sum.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous reset, active-high
//   in_valid_i   upstream operands valid
//   in_ready_o   unit can accept operands (combinational from state)
//   a_i, b_i     8-bit operands, sampled only at accept
//   op_i         [0]: 1 = subtract (A-B), 0 = add; [1]: saturate select
//   out_valid_o  result_o and flags_o valid
//   out_ready_i  downstream accepts result
//   result_o     8-bit sum or difference
//   flags_o      {N, Z, C, V}

module nibble_seq_addsub (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid_i,
  output logic       in_ready_o,
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic [1:0] op_i,
  output logic       out_valid_o,
  input  logic       out_ready_i,
  output logic [7:0] result_o,
  output logic [3:0] flags_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LO   = 2'd1,
    S_HI   = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] a_q, a_d;
  logic [7:0] b_q, b_d;
  logic [1:0] op_q, op_d;
  logic [3:0] sum_lo_q, sum_lo_d;
  logic       c4_q, c4_d;
  logic [7:0] result_q, result_d;
  logic [3:0] flags_q, flags_d;

  // Subtraction is A + ~B + 1; the +1 enters as the low-nibble carry-in.
  logic [7:0] b_eff;
  assign b_eff = op_q[0] ? ~b_q : b_q;

  // ------------------------------------------------------------------
  // Shared 4-bit carry-lookahead nibble adder
  // ------------------------------------------------------------------
  logic       use_hi;
  logic [3:0] nib_a, nib_b, nib_p, nib_g, nib_s;
  logic       nib_cin;
  logic [4:0] nib_c;

  assign use_hi  = (state_q == S_HI);
  assign nib_a   = use_hi ? a_q[7:4]   : a_q[3:0];
  assign nib_b   = use_hi ? b_eff[7:4] : b_eff[3:0];
  assign nib_cin = use_hi ? c4_q       : op_q[0];

  assign nib_p = nib_a ^ nib_b;
  assign nib_g = nib_a & nib_b;

  // Fully expanded lookahead carries: no ripple through the nibble.
  assign nib_c[0] = nib_cin;
  assign nib_c[1] = nib_g[0] | (nib_p[0] & nib_cin);
  assign nib_c[2] = nib_g[1] | (nib_p[1] & nib_g[0])
                  | (nib_p[1] & nib_p[0] & nib_cin);
  assign nib_c[3] = nib_g[2] | (nib_p[2] & nib_g[1])
                  | (nib_p[2] & nib_p[1] & nib_g[0])
                  | (nib_p[2] & nib_p[1] & nib_p[0] & nib_cin);
  assign nib_c[4] = nib_g[3] | (nib_p[3] & nib_g[2])
                  | (nib_p[3] & nib_p[2] & nib_g[1])
                  | (nib_p[3] & nib_p[2] & nib_p[1] & nib_g[0])
                  | (nib_p[3] & nib_p[2] & nib_p[1] & nib_p[0] & nib_cin);

  assign nib_s = nib_p ^ nib_c[3:0];

  // ------------------------------------------------------------------
  // Final result and flags, valid during HI (captured at HI->DONE)
  // ------------------------------------------------------------------
  logic [7:0] raw_sum;
  logic       raw_c8;
  logic       raw_ovf;
  logic [7:0] final_res;

  assign raw_sum = {nib_s, sum_lo_q};
  assign raw_c8  = nib_c[4];
  // Signed overflow: operands (after B inversion) agree in sign but the sum does not.
  assign raw_ovf = (a_q[7] == b_eff[7]) && (raw_sum[7] != a_q[7]);

`ifdef NSA_SAT_EN
  // On overflow the true result's sign equals A's sign, so clamp toward it.
  assign final_res = (op_q[1] && raw_ovf) ? (a_q[7] ? 8'h80 : 8'h7F) : raw_sum;
`else
  // op_q[1] has no consumer when saturation is compiled out.
  logic unused_sat_sel;
  assign unused_sat_sel = op_q[1];
  assign final_res      = raw_sum;
`endif

  // ------------------------------------------------------------------
  // Handshake outputs
  // ------------------------------------------------------------------
  assign in_ready_o  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready_i);
  assign out_valid_o = (state_q == S_DONE);
  assign result_o    = result_q;
  assign flags_o     = flags_q;

  logic accept;
  assign accept = in_valid_i && in_ready_o;

  // ------------------------------------------------------------------
  // Next-state logic
  // ------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    sum_lo_d = sum_lo_q;
    c4_d     = c4_q;
    result_d = result_q;
    flags_d  = flags_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          a_d     = a_i;
          b_d     = b_i;
          op_d    = op_i;
          state_d = S_LO;
        end
      end
      S_LO: begin
        sum_lo_d = nib_s;
        c4_d     = nib_c[4];
        state_d  = S_HI;
      end
      S_HI: begin
        result_d = final_res;
        // C and V describe the raw sum; N and Z the (possibly clamped) result.
        flags_d  = {final_res[7], (final_res == 8'h00), raw_c8, raw_ovf};
        state_d  = S_DONE;
      end
      S_DONE: begin
        if (out_ready_i) begin
          if (in_valid_i) begin
            a_d     = a_i;
            b_d     = b_i;
            op_d    = op_i;
            state_d = S_LO;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ------------------------------------------------------------------
  // State registers
  // ------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_q      <= 8'h00;
      b_q      <= 8'h00;
      op_q     <= 2'b00;
      sum_lo_q <= 4'h0;
      c4_q     <= 1'b0;
      result_q <= 8'h00;
      flags_q  <= 4'h0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      sum_lo_q <= sum_lo_d;
      c4_q     <= c4_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

endmodule

// File: tb/tb_nibble_seq_addsub.sv
module tb_nibble_seq_addsub;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid_i;
  logic       in_ready_o;
  logic [7:0] a_i;
  logic [7:0] b_i;
  logic [1:0] op_i;
  logic       out_valid_o;
  logic       out_ready_i;
  logic [7:0] result_o;
  logic [3:0] flags_o;

  int n_cmp = 0;
  int n_err = 0;

  nibble_seq_addsub dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .a_i         (a_i),
    .b_i         (b_i),
    .op_i        (op_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .result_o    (result_o),
    .flags_o     (flags_o)
  );

  always #5 clk = ~clk;

  // Reference model: plain integer arithmetic. Returns {flags, result}.
  function automatic logic [11:0] model(input logic [7:0] a, input logic [7:0] b,
                                        input logic [1:0] op);
    int ua, ub, sa, sb, ures, sres;
    logic c, v, n, z;
    logic [7:0] res;
    ua = int'(a);
    ub = int'(b);
    sa = (ua > 127) ? ua - 256 : ua;
    sb = (ub > 127) ? ub - 256 : ub;
    if (op[0]) begin
      ures = ua - ub;
      sres = sa - sb;
      c    = (ua >= ub);
    end else begin
      ures = ua + ub;
      sres = sa + sb;
      c    = (ures > 255);
    end
    v   = (sres > 127) || (sres < -128);
    res = 8'(ures & 255);
`ifdef NSA_SAT_EN
    if (op[1] && v) res = (sres > 127) ? 8'h7F : 8'h80;
`endif
    n = res[7];
    z = (res == 8'h00);
    return {n, z, c, v, res};
  endfunction

  // Drive one operation from IDLE with out_ready_i=1; returns the result
  // seen while out_valid is high and the cycles from accept to out_valid.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                        output logic [7:0] r, output logic [3:0] f, output int lat);
    a_i = a; b_i = b; op_i = op; in_valid_i = 1'b1;
    @(posedge clk); #1;
    in_valid_i = 1'b0;
    a_i = 8'($urandom); b_i = 8'($urandom); op_i = 2'($urandom);
    lat = 0;
    while (!out_valid_o && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    r = result_o;
    f = flags_o;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid_i = 1'b0; out_ready_i = 1'b1;
    a_i = 8'h00; b_i = 8'h00; op_i = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (in_ready_o !== 1'b1 || out_valid_o !== 1'b0 || result_o !== 8'h00 || flags_o !== 4'h0) begin
      n_err++;
      $display("FAIL reset: in_ready=%b out_valid=%b result=%h flags=%b, required 1 0 00 0000",
               in_ready_o, out_valid_o, result_o, flags_o);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    $display("reset released: in_ready=%b out_valid=%b", in_ready_o, out_valid_o);
  endtask

  task automatic test_directed;
    logic [7:0] ta [7];
    logic [7:0] tb [7];
    logic [1:0] top [7];
    logic [7:0] er [7];
    logic [3:0] ef [7];
    logic [7:0] r;
    logic [3:0] f;
    int lat;
    ta[0] = 8'h3C; tb[0] = 8'h45; top[0] = 2'b00; er[0] = 8'h81; ef[0] = 4'b1001;
    ta[1] = 8'hFF; tb[1] = 8'h01; top[1] = 2'b00; er[1] = 8'h00; ef[1] = 4'b0110;
    ta[2] = 8'h00; tb[2] = 8'h01; top[2] = 2'b01; er[2] = 8'hFF; ef[2] = 4'b1000;
    ta[3] = 8'h10; tb[3] = 8'h01; top[3] = 2'b01; er[3] = 8'h0F; ef[3] = 4'b0010;
`ifdef NSA_SAT_EN
    ta[4] = 8'h3C; tb[4] = 8'h45; top[4] = 2'b10; er[4] = 8'h7F; ef[4] = 4'b0001;
    ta[5] = 8'h80; tb[5] = 8'h01; top[5] = 2'b11; er[5] = 8'h80; ef[5] = 4'b1011;
`else
    ta[4] = 8'h3C; tb[4] = 8'h45; top[4] = 2'b10; er[4] = 8'h81; ef[4] = 4'b1001;
    ta[5] = 8'h80; tb[5] = 8'h01; top[5] = 2'b11; er[5] = 8'h7F; ef[5] = 4'b0011;
`endif
    ta[6] = 8'h80; tb[6] = 8'h80; top[6] = 2'b00; er[6] = 8'h00; ef[6] = 4'b0111;
    for (int i = 0; i < 7; i++) begin
      run_op(ta[i], tb[i], top[i], r, f, lat);
      $display("directed %0d: %h op%b %h -> result=%h flags=%b lat=%0d", i, ta[i], top[i], tb[i], r, f, lat);
      n_cmp++;
      if (r !== er[i] || f !== ef[i] || lat != 2) begin
        n_err++;
        $display("FAIL directed_%0d: result=%h flags=%b lat=%0d, required result=%h flags=%b lat=2",
                 i, r, f, lat, er[i], ef[i]);
      end
    end
    n_cmp++;
    if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin
      n_err++;
      $display("FAIL idle_after_handshake: out_valid=%b in_ready=%b, required 0 1", out_valid_o, in_ready_o);
    end
  endtask

  task automatic test_random;
    logic [7:0] a, b, r;
    logic [1:0] op;
    logic [3:0] f;
    logic [11:0] e;
    int lat;
    for (int i = 0; i < 40; i++) begin
      a = 8'($urandom); b = 8'($urandom); op = 2'($urandom);
      e = model(a, b, op);
      run_op(a, b, op, r, f, lat);
      $display("random %0d: %h op%b %h -> result=%h flags=%b", i, a, op, b, r, f);
      n_cmp++;
      if ({f, r} !== e || lat != 2) begin
        n_err++;
        $display("FAIL random_%0d: result=%h flags=%b lat=%0d, required result=%h flags=%b lat=2",
                 i, r, f, lat, e[7:0], e[11:8]);
      end
    end
  endtask

  task automatic test_reset_mid_hi;
    logic [7:0] r;
    logic [3:0] f;
    logic [11:0] e;
    int lat;
    int bad;
    a_i = 8'h7E; b_i = 8'h13; op_i = 2'b00; in_valid_i = 1'b1;
    @(posedge clk); #1;          // LO
    in_valid_i = 1'b0;
    @(posedge clk); #1;          // HI
    rst = 1'b1;
    #1;
    n_cmp++;
    if (out_valid_o !== 1'b0 || result_o !== 8'h00 || flags_o !== 4'h0 || in_ready_o !== 1'b1) begin
      n_err++;
      $display("FAIL reset_mid_hi: out_valid=%b result=%h flags=%b in_ready=%b, required 0 00 0000 1",
               out_valid_o, result_o, flags_o, in_ready_o);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      if (out_valid_o !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL reset_no_pulse: out_valid seen high %0d cycles, required 0", bad);
    end
    e = model(8'h21, 8'h34, 2'b01);
    run_op(8'h21, 8'h34, 2'b01, r, f, lat);
    $display("post-reset op: result=%h flags=%b lat=%0d", r, f, lat);
    n_cmp++;
    if ({f, r} !== e || lat != 2) begin
      n_err++;
      $display("FAIL post_reset_op: result=%h flags=%b lat=%0d, required result=%h flags=%b lat=2",
               r, f, lat, e[7:0], e[11:8]);
    end
  endtask

  task automatic test_backpressure;
    logic [7:0] a1, b1, a2, b2, r0;
    logic [1:0] op1, op2;
    logic [3:0] f0;
    logic [11:0] e1, e2;
    int lat, bad;
    a1 = 8'($urandom); b1 = 8'($urandom); op1 = 2'($urandom);
    a2 = 8'($urandom); b2 = 8'($urandom); op2 = 2'($urandom);
    e1 = model(a1, b1, op1);
    e2 = model(a2, b2, op2);
    out_ready_i = 1'b0;
    a_i = a1; b_i = b1; op_i = op1; in_valid_i = 1'b1;
    @(posedge clk); #1;
    in_valid_i = 1'b0;
    lat = 0;
    while (!out_valid_o && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    r0 = result_o; f0 = flags_o;
    n_cmp++;
    if ({f0, r0} !== e1 || lat != 2) begin
      n_err++;
      $display("FAIL bp_first: result=%h flags=%b lat=%0d, required result=%h flags=%b lat=2",
               r0, f0, lat, e1[7:0], e1[11:8]);
    end
    // Hold off the consumer while the next operands wait on the input.
    a_i = a2; b_i = b2; op_i = op2; in_valid_i = 1'b1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (out_valid_o !== 1'b1 || in_ready_o !== 1'b0 || result_o !== r0 || flags_o !== f0) bad++;
      @(posedge clk); #1;
    end
    $display("backpressure: held %0d cycles, result=%h flags=%b", 5, result_o, flags_o);
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL bp_hold: %0d unstable cycles, required 0 (result=%h flags=%b)", bad, result_o, flags_o);
    end
    out_ready_i = 1'b1;
    #1;
    n_cmp++;
    if (in_ready_o !== 1'b1) begin
      n_err++;
      $display("FAIL bp_release_ready: in_ready=%b, required 1", in_ready_o);
    end
    @(posedge clk); #1;          // handshake + same-cycle accept
    in_valid_i = 1'b0;
    a_i = 8'($urandom); b_i = 8'($urandom);
    lat = 1;
    while (!out_valid_o && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    $display("back-to-back after bp: result=%h flags=%b gap=%0d", result_o, flags_o, lat);
    n_cmp++;
    if ({flags_o, result_o} !== e2 || lat != 3) begin
      n_err++;
      $display("FAIL bp_b2b: result=%h flags=%b gap=%0d, required result=%h flags=%b gap=3",
               result_o, flags_o, lat, e2[7:0], e2[11:8]);
    end
    @(posedge clk); #1;          // consume, back to IDLE
  endtask

  task automatic test_back_to_back;
    logic [11:0] exp_q[$];
    logic [11:0] e;
    logic [7:0] a, b;
    logic [1:0] op;
    int sent, got, last;
    localparam int N = 12;
    sent = 0; got = 0; last = -1;
    out_ready_i = 1'b1;
    for (int c = 0; c < 300 && got < N; c++) begin
      if (out_valid_o) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL b2b_extra: unexpected result=%h flags=%b", result_o, flags_o);
        end else begin
          e = exp_q.pop_front();
          $display("b2b %0d: result=%h flags=%b cycle=%0d", got, result_o, flags_o, c);
          n_cmp++;
          if ({flags_o, result_o} !== e || (got > 0 && c - last != 3)) begin
            n_err++;
            $display("FAIL b2b_%0d: result=%h flags=%b gap=%0d, required result=%h flags=%b gap=3",
                     got, result_o, flags_o, c - last, e[7:0], e[11:8]);
          end
        end
        last = c;
        got++;
      end
      if (in_ready_o && sent < N) begin
        a = 8'($urandom); b = 8'($urandom); op = 2'($urandom);
        a_i = a; b_i = b; op_i = op; in_valid_i = 1'b1;
        exp_q.push_back(model(a, b, op));
        sent++;
      end else if (sent >= N) begin
        in_valid_i = 1'b0;
      end
      @(posedge clk); #1;
    end
    in_valid_i = 1'b0;
    n_cmp++;
    if (got != N) begin
      n_err++;
      $display("FAIL b2b_count: received %0d results, required %0d", got, N);
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_random;
    test_reset_mid_hi;
    test_backpressure;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
